// File: rtl/dense_argmax_classifier.sv
// -----------------------------------------------------------------------------
// dense_argmax_classifier
//
// Fully-connected classifier layer followed by an arg-max. The feature vector
// is captured on an accepted start. Each class score is accumulated LANES
// products per cycle. The sum is rescaled by FRAC_BITS, biased and saturated
// to DATA_WIDTH. The block then reports the best class, its score and whether
// any class clamped.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle request, sampled only while idle
//   in_vec[]     signed features, captured on accepted start
//   wt[]         signed weights, class c element n at c*IN_LEN+n, stable while busy
//   bias[]       signed per-class bias (same Q format), stable while busy
//   busy         high from accepted start through the done cycle
//   done         one-cycle pulse, result valid
//   class_idx    arg-max class index
//   class_score  saturated score of class_idx
//   sat_flag     some class score clamped during this inference
//   dbg_state    current FSM state (0 idle, 1 mac, 2 done)
//
// Handshake: start is honoured only in IDLE and is never queued. Exactly
// NUM_CLASS*K cycles after the accepting edge, done pulses for one cycle and
// busy falls with it. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module dense_argmax_classifier #(
   parameter int IN_LEN     = 16,
   parameter int NUM_CLASS  = 6,
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int LANES      = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic signed [DATA_WIDTH-1:0]        in_vec [0:IN_LEN-1],
   input  logic signed [DATA_WIDTH-1:0]        wt     [0:NUM_CLASS*IN_LEN-1],
   input  logic signed [DATA_WIDTH-1:0]        bias   [0:NUM_CLASS-1],
   output logic                                busy,
   output logic                                done,
   output logic [$clog2(NUM_CLASS)-1:0]        class_idx,
   output logic signed [DATA_WIDTH-1:0]        class_score,
   output logic                                sat_flag,
   output logic [1:0]                          dbg_state
);

   localparam int K     = IN_LEN / LANES;
   localparam int ACC_W = 2*DATA_WIDTH + $clog2(IN_LEN) + 1;
   localparam int IDX_W = $clog2(NUM_CLASS);
   localparam int PW    = 2*DATA_WIDTH;
   localparam int KW    = (K > 1) ? $clog2(K) : 1;
   localparam int FI_W  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
   localparam int WI_W  = $clog2(NUM_CLASS*IN_LEN);

   localparam logic [KW-1:0]    K_LAST = KW'(K-1);
   localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_CLASS-1);
   // Clamp limits, held at accumulator width so the compare is exact.
   localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DATA_WIDTH-1)) - 1);
   localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic signed [DATA_WIDTH-1:0] r_feat [0:IN_LEN-1];
   logic [IDX_W-1:0]             r_c;
   logic [KW-1:0]                r_k;
   logic signed [ACC_W-1:0]      r_acc;
   logic signed [DATA_WIDTH-1:0] r_max;
   logic [IDX_W-1:0]             r_idx;
   logic                         r_sticky;
   logic                         r_busy;
   logic                         r_done;
   logic [IDX_W-1:0]             r_class_idx;
   logic signed [DATA_WIDTH-1:0] r_class_score;
   logic                         r_sat_flag;

   logic [31:0]                  w_fi;
   logic [31:0]                  w_wi;
   logic signed [PW-1:0]         w_prod;
   logic signed [ACC_W-1:0]      w_sum;
   logic signed [ACC_W-1:0]      w_shift;
   logic signed [ACC_W-1:0]      w_score_full;
   logic signed [DATA_WIDTH-1:0] w_bias_c;
   logic signed [DATA_WIDTH-1:0] w_score;
   logic                         w_clamp;
   logic                         w_take;
   logic                         w_last_chunk;
   logic                         w_last_class;

   assign w_last_chunk = (r_k == K_LAST);
   assign w_last_class = (r_c == C_LAST);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_MAC;
         S_MAC:   if (w_last_chunk && w_last_class) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- MAC datapath ----------------
   // One chunk of LANES products is added to the running sum each cycle.
   always_comb begin
      w_fi   = '0;
      w_wi   = '0;
      w_prod = '0;
      w_sum  = r_acc;
      for (int l = 0; l < LANES; l++) begin
         w_fi   = 32'(r_k) * LANES + 32'(l);
         w_wi   = 32'(r_c) * IN_LEN + w_fi;
         w_prod = r_feat[w_fi[FI_W-1:0]] * wt[w_wi[WI_W-1:0]];
         w_sum  = w_sum + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
      end
   end

   // Arithmetic shift truncates toward -inf; the bias is already in output Q format.
   assign w_bias_c     = bias[r_c];
   assign w_shift      = w_sum >>> FRAC_BITS;
   assign w_score_full = w_shift + {{(ACC_W-DATA_WIDTH){w_bias_c[DATA_WIDTH-1]}}, w_bias_c};

   always_comb begin
      w_clamp = 1'b0;
      w_score = w_score_full[DATA_WIDTH-1:0];
      if (w_score_full > S_MAX) begin
         w_score = S_MAX[DATA_WIDTH-1:0];
         w_clamp = 1'b1;
      end else if (w_score_full < S_MIN) begin
         w_score = S_MIN[DATA_WIDTH-1:0];
         w_clamp = 1'b1;
      end
   end

   // Strict compare, so the lowest index wins a tie. Class 0 always seeds the max.
   assign w_take = (r_c == '0) || (w_score > r_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_feat        <= '{default: '0};
         r_c           <= '0;
         r_k           <= '0;
         r_acc         <= '0;
         r_max         <= '0;
         r_idx         <= '0;
         r_sticky      <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_class_idx   <= '0;
         r_class_score <= '0;
         r_sat_flag    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_feat <= in_vec;
                  r_c    <= '0;
                  r_k    <= '0;
                  r_acc  <= '0;
                  r_busy <= 1'b1;
               end
            end
            S_MAC: begin
               if (w_last_chunk) begin
                  r_acc    <= '0;
                  r_k      <= '0;
                  r_c      <= w_last_class ? '0 : r_c + IDX_W'(1);
                  r_max    <= w_take ? w_score : r_max;
                  r_idx    <= w_take ? r_c : r_idx;
                  r_sticky <= r_sticky | w_clamp;
                  // The result registers load on the same edge that raises done,
                  // so the final class is folded in here, not from r_max.
                  if (w_last_class) begin
                     r_class_idx   <= w_take ? r_c : r_idx;
                     r_class_score <= w_take ? w_score : r_max;
                     r_sat_flag    <= r_sticky | w_clamp;
                     r_done        <= 1'b1;
                  end
               end else begin
                  r_acc <= w_sum;
                  r_k   <= r_k + KW'(1);
               end
            end
            S_DONE: begin
               r_done   <= 1'b0;
               r_busy   <= 1'b0;
               r_c      <= '0;
               r_k      <= '0;
               r_acc    <= '0;
               r_max    <= '0;
               r_idx    <= '0;
               r_sticky <= 1'b0;
            end
            default: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign class_idx   = r_class_idx;
   assign class_score = r_class_score;
   assign sat_flag    = r_sat_flag;
   assign dbg_state   = r_state;

endmodule
